// File: rtl/sdram_arb2_if.sv
// Request/completion bus shared by the two core ports and the SDRAM controller side.
// master drives the request, slave returns the completion pulse and read data.
interface sdram_arb2_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   din;
  logic [DATA_W/8-1:0] wmask;
  logic [DATA_W-1:0]   dout;
  logic                ready;

  modport master (output valid, addr, din, wmask, input dout, ready);
  modport slave  (input valid, addr, din, wmask, output dout, ready);
endinterface

// File: rtl/sdram_arb2.sv
// Two-port arbiter in front of a single SDRAM controller, one transaction in flight.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module sdram_arb2 #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  sdram_arb2_if.slave  m0,
  sdram_arb2_if.slave  m1,
  sdram_arb2_if.master mem
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                       r_state, w_state;
  logic                         r_last, w_last;
  logic                         r_gnt, w_gnt;
  logic                         r_mem_valid, w_mem_valid;
  logic [ADDR_W-1:0]            r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]            r_mem_din, w_mem_din;
  logic [MASK_W-1:0]            r_mem_wmask, w_mem_wmask;
  logic [1:0]                   r_rdy, w_rdy;
  logic [1:0][DATA_W-1:0]       r_dout, w_dout;
  logic                         w_win;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign w_win = ~m0.valid;
`else
  // On a tie the port that did not complete last wins; otherwise the lone requester.
  assign w_win = (m0.valid && m1.valid) ? ~r_last : m1.valid;
`endif

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_gnt       = r_gnt;
    w_mem_valid = r_mem_valid;
    w_mem_addr  = r_mem_addr;
    w_mem_din   = r_mem_din;
    w_mem_wmask = r_mem_wmask;
    w_rdy       = '0;
    w_dout      = r_dout;
    case (r_state)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          w_mem_valid = 1'b1;
          w_gnt       = w_win;
          w_mem_addr  = w_win ? m1.addr  : m0.addr;
          w_mem_din   = w_win ? m1.din   : m0.din;
          w_mem_wmask = w_win ? m1.wmask : m0.wmask;
          w_state     = BUSY;
        end
      end
      BUSY: begin
        if (mem.ready) begin
          w_mem_valid  = 1'b0;
          w_rdy[r_gnt] = 1'b1;
          if (r_mem_wmask == '0) w_dout[r_gnt] = mem.dout;
          w_last  = r_gnt;
          w_state = DONE;
        end
      end
      // Requester still holds valid here; skipping arbitration avoids a replay.
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_gnt       <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_wmask <= '0;
      r_rdy       <= '0;
      r_dout      <= '0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_gnt       <= w_gnt;
      r_mem_valid <= w_mem_valid;
      r_mem_addr  <= w_mem_addr;
      r_mem_din   <= w_mem_din;
      r_mem_wmask <= w_mem_wmask;
      r_rdy       <= w_rdy;
      r_dout      <= w_dout;
    end
  end

  assign mem.valid = r_mem_valid;
  assign mem.addr  = r_mem_addr;
  assign mem.din   = r_mem_din;
  assign mem.wmask = r_mem_wmask;
  assign m0.ready  = r_rdy[0];
  assign m1.ready  = r_rdy[1];
  assign m0.dout   = r_dout[0];
  assign m1.dout   = r_dout[1];
endmodule

// File: tb/tb_sdram_arb2.sv
// Bench for sdram_arb2: directed scenarios plus random two-port traffic against a
// transaction-level model (grant rule, byte-masked memory, gap/latency rules).
module tb_sdram_arb2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arb2_if #(.ADDR_W(25), .DATA_W(32)) m0_if ();
  sdram_arb2_if #(.ADDR_W(25), .DATA_W(32)) m1_if ();
  sdram_arb2_if #(.ADDR_W(25), .DATA_W(32)) mem_if ();

  sdram_arb2 #(.ADDR_W(25), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .mem(mem_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic        rq_v [2];
  logic [24:0] rq_a [2];
  logic [31:0] rq_d [2];
  logic [3:0]  rq_m [2];
  logic        vprev [2];
  int          hold [2];
  bit          auto_en [2];
  int          rate, stray_pct, fixed_lat;
  bit          force_stray;
  bit          outstanding, mr_real;
  int          since, lat, cur_g, last_g;
  logic [24:0] cur_a;
  logic [31:0] cur_d, resp;
  logic [3:0]  cur_m;
  logic [31:0] exp_dout [2];
  int          glog [$];
  logic [31:0] mem_m [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [24:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0;
  endfunction

  function automatic int winner();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    return vprev[0] ? 0 : 1;
`else
    if (vprev[0] && vprev[1]) return 1 - last_g;
    return vprev[0] ? 0 : 1;
`endif
  endfunction

  task automatic drive();
    m0_if.valid = rq_v[0]; m0_if.addr = rq_a[0]; m0_if.din = rq_d[0]; m0_if.wmask = rq_m[0];
    m1_if.valid = rq_v[1]; m1_if.addr = rq_a[1]; m1_if.din = rq_d[1]; m1_if.wmask = rq_m[1];
    vprev = rq_v;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      rq_v[p] = 1'b0; rq_a[p] = '0; rq_d[p] = '0; rq_m[p] = '0;
      hold[p] = 0; auto_en[p] = 1'b0; exp_dout[p] = '0;
    end
    outstanding = 1'b0; mr_real = 1'b0; since = 2; last_g = 1; cur_g = 0;
    cur_a = '0; cur_d = '0; cur_m = '0; resp = '0; lat = 0; force_stray = 1'b0;
    mem_if.ready = 1'b0; mem_if.dout = '0;
    drive();
  endtask

  task automatic new_req(input int p, input logic [24:0] a, input logic [31:0] d, input logic [3:0] m);
    rq_v[p] = 1'b1; rq_a[p] = a; rq_d[p] = d; rq_m[p] = m;
  endtask

  // One clock: check what the DUT shows after the last edge, then play controller and requesters.
  task automatic step();
    logic [1:0]  obs_r;
    logic [31:0] obs_d [2];
    logic        emv;
    int          w;
    @(negedge clk);
    obs_r = {m1_if.ready, m0_if.ready};
    obs_d[0] = m0_if.dout; obs_d[1] = m1_if.dout;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("m%0d_ready", p), obs_r[p], mr_real && cur_g == p);
      if (obs_r[p]) glog.push_back(p);
    end
    if (mr_real) begin
      if (cur_m == 0) exp_dout[cur_g] = resp;
      last_g = cur_g; outstanding = 1'b0; since = 0; hold[cur_g] = 2;
    end else if (since < 2) since++;
    for (int p = 0; p < 2; p++) chk($sformatf("m%0d_dout", p), obs_d[p], exp_dout[p]);
    emv = outstanding ? 1'b1 : (since < 2 ? 1'b0 : (vprev[0] | vprev[1]));
    chk("mem_valid", mem_if.valid, emv);
    if (!outstanding && emv && mem_if.valid) begin
      w = winner();
      cur_g = w; cur_a = rq_a[w]; cur_d = rq_d[w]; cur_m = rq_m[w];
      outstanding = 1'b1;
      lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
    if (outstanding) begin
      chk("mem_addr", mem_if.addr, cur_a);
      chk("mem_din", mem_if.din, cur_d);
      chk("mem_wmask", mem_if.wmask, cur_m);
    end
    mr_real = 1'b0; mem_if.ready = 1'b0; mem_if.dout = $urandom;
    if (outstanding) begin
      if (lat == 0) begin
        mr_real = 1'b1; mem_if.ready = 1'b1;
        if (cur_m != 0) begin
          logic [31:0] old;
          old = rd(cur_a);
          for (int b = 0; b < 4; b++) if (cur_m[b]) old[b*8 +: 8] = cur_d[b*8 +: 8];
          mem_m[int'(cur_a)] = old;
        end else mem_if.dout = rd(cur_a);
        resp = mem_if.dout;
      end else lat--;
    end else if (force_stray || int'($urandom_range(0, 99)) < stray_pct) begin
      mem_if.ready = 1'b1; force_stray = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (hold[p] > 0) begin
        hold[p]--;
        if (hold[p] == 0) rq_v[p] = 1'b0;
      end
      if (!rq_v[p] && hold[p] == 0 && auto_en[p] && int'($urandom_range(0, 99)) < rate)
        new_req(p, 25'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0);
    end
    drive();
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = !rq_v[0] && !rq_v[1] && !outstanding && since >= 2 && hold[0] == 0 && hold[1] == 0;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_busy(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = outstanding;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    rate = 0; stray_pct = 0; fixed_lat = -1;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", mem_if.valid, 1'b0);
    chk("rst_mem_addr", mem_if.addr, 25'h0);
    chk("rst_mem_din", mem_if.din, 32'h0);
    chk("rst_mem_wmask", mem_if.wmask, 4'h0);
    chk("rst_m0_ready", m0_if.ready, 1'b0);
    chk("rst_m1_ready", m1_if.ready, 1'b0);
    chk("rst_m0_dout", m0_if.dout, 32'h0);
    chk("rst_m1_dout", m1_if.dout, 32'h0);
    rst = 1'b0;

    // Single read on port 0
    mem_m[32'h100] = 32'hDEADBEEF;
    new_req(0, 25'h100, 32'h0, 4'h0);
    wait_idle("t1_done", 50);
    chk("t1_m0_dout", m0_if.dout, 32'hDEADBEEF);

    // Write then read back on port 1
    new_req(1, 25'h200, 32'h12345678, 4'hF);
    wait_busy("t2_busy", 20);
    chk("t2_mem_wmask", mem_if.wmask, 4'hF);
    chk("t2_mem_din", mem_if.din, 32'h12345678);
    wait_idle("t2_wr_done", 50);
    chk("t2_m1_dout_kept", m1_if.dout, 32'h0);
    new_req(1, 25'h200, 32'h0, 4'h0);
    wait_idle("t2_rd_done", 50);
    chk("t2_m1_readback", m1_if.dout, 32'h12345678);

    // Dual continuous demand from reset
    do_reset();
    glog.delete();
    rate = 100; auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = glog.size() >= 4;
    end
    chk("t3_grants_seen", ok, 1'b1);
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    for (int i = 0; i < 4 && i < glog.size(); i++)
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      chk($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'd0);
`else
      chk($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'(i % 2));
`endif
    wait_idle("t3_drain", 100);

    // Async reset while BUSY
    fixed_lat = 20;
    new_req(0, 25'h300, 32'h0, 4'h0);
    wait_busy("t5_busy", 20);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t5_mem_valid", mem_if.valid, 1'b0);
    chk("t5_m0_ready", m0_if.ready, 1'b0);
    chk("t5_m1_ready", m1_if.ready, 1'b0);
    chk("t5_m0_dout", m0_if.dout, 32'h0);
    fixed_lat = -1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    new_req(0, 25'h100, 32'h0, 4'h0);
    wait_idle("t5_after", 50);
    chk("t5_m0_dout_after", m0_if.dout, 32'hDEADBEEF);

    // Stray mem_ready while idle
    force_stray = 1'b1;
    repeat (3) step();
    chk("t6_m0_dout", m0_if.dout, 32'hDEADBEEF);
    chk("t6_m1_dout", m1_if.dout, 32'h0);

    // Random mixed traffic with occasional stray completions
    rate = 40; stray_pct = 10; auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    repeat (600) step();
    auto_en[0] = 1'b0; auto_en[1] = 1'b0; stray_pct = 0;
    wait_idle("t7_drain", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
